// File: rtl/litepcie_rc_pkg.sv
// Shared definitions for the requester-completion path: completion status
// codes, the 1024-dword length encoding and the tag manager state type.
package litepcie_rc_pkg;

  localparam logic [2:0]  CPL_STATUS_SC  = 3'd0;
  localparam logic [2:0]  CPL_STATUS_UR  = 3'd1;
  localparam logic [2:0]  CPL_STATUS_CRS = 3'd2;
  localparam logic [2:0]  CPL_STATUS_CA  = 3'd4;

  localparam logic [10:0] LEN_1024 = 11'd1024;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } tag_state_e;

  // A 10-bit PCIe length field of zero means 1024 dwords.
  function automatic logic [10:0] map_len(input logic [9:0] len);
    return (len == 10'd0) ? LEN_1024 : {1'b0, len};
  endfunction

  function automatic logic cpl_status_known(input logic [2:0] status);
    return (status == CPL_STATUS_SC) || (status == CPL_STATUS_UR) ||
           (status == CPL_STATUS_CRS) || (status == CPL_STATUS_CA);
  endfunction

endpackage

// File: rtl/rc_tag_free_fifo.sv
// Free-tag FIFO: synchronous, registered occupancy count, head read
// straight from storage so a push is never visible in the same cycle.
module rc_tag_free_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rc_tag_manager.sv
// Read-request tag manager: round-robin tag allocation to DMA read ports,
// per-tag owner/remaining-dword tracking and completion-driven release.
module rc_tag_manager
  import litepcie_rc_pkg::*;
#(
  parameter int NUM_TAGS   = 32,
  parameter int TAG_WIDTH  = $clog2(NUM_TAGS),
  parameter int NUM_PORTS  = 2,
  parameter int PORT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS*10-1:0] req_len,
  output logic [NUM_PORTS-1:0]    req_ready,
  output logic [TAG_WIDTH-1:0]    req_tag,
  input  logic                    cpl_valid,
  input  logic [7:0]              cpl_tag,
  input  logic [9:0]              cpl_dwlen,
  input  logic [2:0]              cpl_status,
  output logic [PORT_WIDTH-1:0]   cpl_port,
  output logic                    cpl_hit,
  output logic                    done_valid,
  output logic [PORT_WIDTH-1:0]   done_port,
  output logic [TAG_WIDTH-1:0]    done_tag,
  output logic                    done_err,
  output logic                    unexp_cpl,
  output logic [TAG_WIDTH:0]      outstanding,
  output logic                    ready
);

  tag_state_e            state_q, state_d;
  logic [TAG_WIDTH-1:0]  init_cnt_q, init_cnt_d;
  logic [PORT_WIDTH-1:0] rr_last_q, rr_last_d;
  logic [NUM_TAGS-1:0]   busy_q, busy_d;
  logic [PORT_WIDTH-1:0] owner_q [NUM_TAGS];
  logic [10:0]           rem_q [NUM_TAGS];
  logic [TAG_WIDTH:0]    outstanding_q, outstanding_d;

  logic                  done_valid_q;
  logic [PORT_WIDTH-1:0] done_port_q;
  logic [TAG_WIDTH-1:0]  done_tag_q;
  logic                  done_err_q;
  logic                  unexp_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [TAG_WIDTH-1:0]  fifo_push_data;
  logic [TAG_WIDTH-1:0]  fifo_head;
  logic                  fifo_empty;

  logic [9:0]            port_len [NUM_PORTS];
  logic [PORT_WIDTH:0]   cand;
  logic [PORT_WIDTH-1:0] grant_idx;
  logic                  grant_found;
  logic                  grant_en;
  logic [10:0]           grant_len;

  logic [TAG_WIDTH-1:0]  cpl_idx;
  logic                  cpl_in_range;
  logic [10:0]           cpl_rem;
  logic [10:0]           cpl_len;
  logic [10:0]           cpl_new;
  logic                  cpl_under;
  logic                  cpl_err;
  logic                  rel_en;
  logic                  cpl_update;

  rc_tag_free_fifo #(
    .DEPTH (NUM_TAGS),
    .WIDTH (TAG_WIDTH)
  ) u_free_fifo (
    .clk_i       (user_clk),
    .rst_i       (user_reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty)
  );

  // Round-robin search starts one past the most recently granted port.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, rr_last_q} + (PORT_WIDTH+1)'(k);
      if (cand >= (PORT_WIDTH+1)'(NUM_PORTS)) cand = cand - (PORT_WIDTH+1)'(NUM_PORTS);
      if (!grant_found && req_valid[cand[PORT_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PORT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_len[i] = req_len[i*10 +: 10];
    end
  end

  assign grant_en  = (state_q == ST_RUN) && !fifo_empty && grant_found;
  assign grant_len = map_len(port_len[grant_idx]);
  assign req_tag   = fifo_head;
  assign fifo_pop  = grant_en;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ready[i] = grant_en && (grant_idx == PORT_WIDTH'(i));
    end
  end

  // Underflow is judged before subtracting so the wrapped difference is ignored.
  assign cpl_idx      = cpl_tag[TAG_WIDTH-1:0];
  assign cpl_in_range = ((cpl_tag >> TAG_WIDTH) == 8'd0);
  assign cpl_hit      = cpl_in_range && busy_q[cpl_idx];
  assign cpl_port     = cpl_in_range ? owner_q[cpl_idx] : '0;
  assign cpl_rem      = rem_q[cpl_idx];
  assign cpl_len      = map_len(cpl_dwlen);
  assign cpl_under    = (cpl_len > cpl_rem);
  assign cpl_new      = cpl_rem - cpl_len;
  assign cpl_err      = (cpl_status != CPL_STATUS_SC) || cpl_under;
  assign rel_en       = cpl_valid && cpl_hit && (cpl_err || (cpl_new == 11'd0));
  assign cpl_update   = cpl_valid && cpl_hit && !rel_en;

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    rr_last_d      = rr_last_q;
    busy_d         = busy_q;
    outstanding_d  = outstanding_q;
    fifo_push      = 1'b0;
    fifo_push_data = cpl_idx;

    case (state_q)
      ST_INIT: begin
        fifo_push      = 1'b1;
        fifo_push_data = init_cnt_q;
        init_cnt_d     = init_cnt_q + 1'b1;
        if (init_cnt_q == TAG_WIDTH'(NUM_TAGS - 1)) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase

    if (grant_en) begin
      busy_d[fifo_head] = 1'b1;
      rr_last_d         = grant_idx;
    end

    if (rel_en) begin
      busy_d[cpl_idx] = 1'b0;
      fifo_push       = 1'b1;
      fifo_push_data  = cpl_idx;
    end

    case ({grant_en, rel_en})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      rr_last_q     <= PORT_WIDTH'(NUM_PORTS - 1);
      busy_q        <= '0;
      outstanding_q <= '0;
      done_valid_q  <= 1'b0;
      done_port_q   <= '0;
      done_tag_q    <= '0;
      done_err_q    <= 1'b0;
      unexp_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rr_last_q     <= rr_last_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      done_valid_q  <= rel_en;
      unexp_q       <= cpl_valid && !cpl_hit;
      if (rel_en) begin
        done_port_q <= owner_q[cpl_idx];
        done_tag_q  <= cpl_idx;
        done_err_q  <= cpl_err;
      end
    end
  end

  // Table contents are qualified by busy, so they need no reset.
  always_ff @(posedge user_clk) begin
    if (grant_en) begin
      owner_q[fifo_head] <= grant_idx;
      rem_q[fifo_head]   <= grant_len;
    end
    if (cpl_update) rem_q[cpl_idx] <= cpl_new;
  end

  assign done_valid  = done_valid_q;
  assign done_port   = done_port_q;
  assign done_tag    = done_tag_q;
  assign done_err    = done_err_q;
  assign unexp_cpl   = unexp_q;
  assign outstanding = outstanding_q;
  assign ready       = (state_q == ST_RUN);

endmodule

// File: tb/tb_rc_tag_manager.sv
// Scoreboard bench for rc_tag_manager: a queue-based reference model predicts
// grants, completion lookups and done/unexpected events cycle by cycle.
module tb_rc_tag_manager;

  localparam int NT = 32;
  localparam int TW = 5;
  localparam int NP = 2;
  localparam int PW = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [NP-1:0] reqValid;
  logic [NP*10-1:0] reqLen;
  logic [NP-1:0] reqReady;
  logic [TW-1:0] reqTag;
  logic          cplValid;
  logic [7:0]    cplTag;
  logic [9:0]    cplDwlen;
  logic [2:0]    cplStatus;
  logic [PW-1:0] cplPort;
  logic          cplHit;
  logic          doneValid;
  logic [PW-1:0] donePort;
  logic [TW-1:0] doneTag;
  logic          doneErr;
  logic          unexpCpl;
  logic [TW:0]   outstanding;
  logic          ready;

  always #5 clock = ~clock;

  rc_tag_manager #(
    .NUM_TAGS  (NT),
    .NUM_PORTS (NP)
  ) dut (
    .user_clk    (clock),
    .user_reset  (reset),
    .req_valid   (reqValid),
    .req_len     (reqLen),
    .req_ready   (reqReady),
    .req_tag     (reqTag),
    .cpl_valid   (cplValid),
    .cpl_tag     (cplTag),
    .cpl_dwlen   (cplDwlen),
    .cpl_status  (cplStatus),
    .cpl_port    (cplPort),
    .cpl_hit     (cplHit),
    .done_valid  (doneValid),
    .done_port   (donePort),
    .done_tag    (doneTag),
    .done_err    (doneErr),
    .unexp_cpl   (unexpCpl),
    .outstanding (outstanding),
    .ready       (ready)
  );

  typedef struct {
    int      cyc;
    bit      chk;
    bit [NP-1:0] rdy;
    int      tag;
    bit      hit;
    int      port;
  } combExp_t;

  typedef struct {
    int cyc;
    bit all;
    bit dv;
    int dport;
    int dtag;
    bit derr;
    bit unexp;
    int outst;
    bit rdy;
  } regExp_t;

  combExp_t combQ[$];
  regExp_t  regQ[$];

  int freeQ[$];
  bit busyM[NT];
  int ownerM[NT];
  int remM[NT];
  int lastPort   = NP - 1;
  int outstM     = 0;
  bit readyM     = 1'b0;
  int initNext   = 0;
  bit modelValid = 1'b0;

  int cyc        = 0;
  int checkCount = 0;
  int passCount  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    else
      passCount++;
  endtask

  // One clock of stimulus: drive inputs, predict this cycle's combinational
  // outputs and the next cycle's registered outputs, then advance the model.
  task automatic applyStimulus(input bit rst, input bit [NP-1:0] v, input int len0, input int len1,
                               input bit cv, input int ctag, input int cdw, input int cst);
    combExp_t ce;
    regExp_t  re;
    int gp;
    int p;
    int t;
    int dw;
    int glen;
    bit hitM;
    bit rel;
    bit err;

    reset     = rst;
    reqValid  = v;
    reqLen    = {10'(len1), 10'(len0)};
    cplValid  = cv;
    cplTag    = 8'(ctag);
    cplDwlen  = 10'(cdw);
    cplStatus = 3'(cst);

    gp = -1;
    if (readyM && freeQ.size() > 0) begin
      for (int k = 1; k <= NP; k++) begin
        p = (lastPort + k) % NP;
        if (gp < 0 && v[p]) gp = p;
      end
    end
    hitM = 1'b0;
    if (ctag < NT) hitM = busyM[ctag];

    ce.cyc  = cyc;
    ce.chk  = modelValid;
    ce.rdy  = '0;
    ce.tag  = 0;
    if (gp >= 0) begin
      ce.rdy[gp] = 1'b1;
      ce.tag     = freeQ[0];
    end
    ce.hit  = hitM;
    ce.port = hitM ? ownerM[ctag] : 0;
    combQ.push_back(ce);

    re = '{cyc: cyc + 1, all: 1'b0, dv: 1'b0, dport: 0, dtag: 0, derr: 1'b0, unexp: 1'b0, outst: 0, rdy: 1'b0};
    if (rst) begin
      re.all   = 1'b1;
      freeQ.delete();
      foreach (busyM[i]) busyM[i] = 1'b0;
      lastPort = NP - 1;
      outstM   = 0;
      readyM   = 1'b0;
      initNext = 0;
    end else begin
      rel = 1'b0;
      err = 1'b0;
      if (cv) begin
        if (!hitM) begin
          re.unexp = 1'b1;
        end else begin
          dw = (cdw == 0) ? 1024 : cdw;
          if (cst != 0 || dw > remM[ctag]) begin
            rel = 1'b1;
            err = 1'b1;
          end else if (dw == remM[ctag]) begin
            rel = 1'b1;
          end else begin
            remM[ctag] = remM[ctag] - dw;
          end
        end
      end
      re.dv = rel;
      if (rel) begin
        re.dport = ownerM[ctag];
        re.dtag  = ctag;
        re.derr  = err;
      end
      if (!readyM) begin
        freeQ.push_back(initNext);
        initNext++;
        if (initNext == NT) readyM = 1'b1;
      end else begin
        if (gp >= 0) begin
          t         = freeQ.pop_front();
          glen      = (gp == 0) ? len0 : len1;
          busyM[t]  = 1'b1;
          ownerM[t] = gp;
          remM[t]   = (glen == 0) ? 1024 : glen;
          lastPort  = gp;
          outstM++;
        end
        if (rel) begin
          busyM[ctag] = 1'b0;
          freeQ.push_back(ctag);
          outstM--;
        end
      end
    end
    re.outst = outstM;
    re.rdy   = readyM;
    regQ.push_back(re);
    modelValid = 1'b1;

    @(posedge clock);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1, 1, 1'b0, 0, 1, 0);
  endtask

  task automatic cplCycle(input int ctag, input int cdw, input int cst);
    applyStimulus(1'b0, '0, 1, 1, 1'b1, ctag, cdw, cst);
  endtask

  always @(negedge clock) begin
    combExp_t ce;
    regExp_t  re;
    if (combQ.size() > 0 && combQ[0].cyc == cyc) begin
      ce = combQ.pop_front();
      if (ce.chk) begin
        checkOutput("req_ready", 32'(reqReady), 32'(ce.rdy));
        if (ce.rdy != 0) checkOutput("req_tag", 32'(reqTag), ce.tag);
        checkOutput("cpl_hit", 32'(cplHit), 32'(ce.hit));
        if (ce.hit) checkOutput("cpl_port", 32'(cplPort), ce.port);
      end
    end
    if (regQ.size() > 0 && regQ[0].cyc == cyc) begin
      re = regQ.pop_front();
      checkOutput("done_valid", 32'(doneValid), 32'(re.dv));
      if (re.dv || re.all) begin
        checkOutput("done_port", 32'(donePort), re.dport);
        checkOutput("done_tag", 32'(doneTag), re.dtag);
        checkOutput("done_err", 32'(doneErr), 32'(re.derr));
      end
      checkOutput("unexp_cpl", 32'(unexpCpl), 32'(re.unexp));
      checkOutput("outstanding", 32'(outstanding), re.outst);
      checkOutput("ready", 32'(ready), 32'(re.rdy));
    end
  end

  initial begin
    int busyList[$];
    int t;
    int dw;
    int st;
    int r;

    reset     = 1'b1;
    reqValid  = '0;
    reqLen    = '0;
    cplValid  = 1'b0;
    cplTag    = '0;
    cplDwlen  = '0;
    cplStatus = '0;

    repeat (3) applyStimulus(1'b1, '0, 1, 1, 1'b0, 0, 1, 0);
    repeat (NT + 1) idleCycle();

    repeat (3) applyStimulus(1'b0, 2'b01, 64, 64, 1'b0, 0, 1, 0);
    repeat (31) applyStimulus(1'b0, 2'b11, 64, 64, 1'b0, 0, 1, 0);

    cplCycle(5, 32, 0);
    cplCycle(5, 32, 0);
    cplCycle(3, 4, 1);
    cplCycle(4, 80, 0);
    cplCycle(5, 8, 0);
    cplCycle(40, 8, 0);
    cplCycle(9, 0, 0);
    cplCycle(6, 63, 0);
    cplCycle(6, 1, 0);
    idleCycle();

    repeat (4) applyStimulus(1'b0, 2'b01, 16, 16, 1'b0, 0, 1, 0);
    applyStimulus(1'b0, 2'b10, 16, 16, 1'b1, 7, 64, 0);
    applyStimulus(1'b0, 2'b10, 16, 16, 1'b0, 7, 1, 0);
    idleCycle();

    for (int i = 0; i < 1200; i++) begin
      if (i == 600 || i == 601) begin
        applyStimulus(1'b1, '0, 1, 1, 1'b0, 0, 1, 0);
        continue;
      end
      busyList.delete();
      foreach (busyM[k]) if (busyM[k]) busyList.push_back(k);
      r = $urandom_range(99);
      if (r < 60 && busyList.size() > 0) begin
        t  = busyList[$urandom_range(busyList.size() - 1)];
        st = ($urandom_range(99) < 8) ? ((1 << $urandom_range(2)) & 7) : 0;
        if ($urandom_range(9) == 0) dw = remM[t] + $urandom_range(4, 1);
        else dw = $urandom_range(remM[t], 1);
        if (dw > 1024) dw = 1024;
        applyStimulus(1'b0, NP'($urandom_range(3)), $urandom_range(12), $urandom_range(12, 1),
                      1'b1, t, (dw == 1024) ? 0 : dw, st);
      end else if (r < 70) begin
        applyStimulus(1'b0, NP'($urandom_range(3)), $urandom_range(12, 1), $urandom_range(12, 1),
                      1'b1, $urandom_range(63), $urandom_range(8, 1), 0);
      end else begin
        applyStimulus(1'b0, NP'($urandom_range(3)), $urandom_range(12, 1), $urandom_range(12),
                      1'b0, $urandom_range(63), 1, 0);
      end
    end

    repeat (2) idleCycle();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
